// File: rtl/shift_pkg.sv
// Shared types and reference shift helpers for the shifter datapath.
// Used by the shift unit and the shifter arbiter.
package shift_pkg;

    localparam int N       = 32;
    localparam int SHAMT_W = $clog2(N);

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_PASS = 2'b11
    } shift_op_t;

    typedef struct packed {
        shift_op_t          op;
        logic [N-1:0]       in;
        logic [SHAMT_W-1:0] shamt;
    } shift_req_t;

    function automatic logic [N-1:0] shift_left_logical(
        input logic [N-1:0]       a,
        input logic [SHAMT_W-1:0] s
    );
        return a << s;
    endfunction

    function automatic logic [N-1:0] shift_right_logical(
        input logic [N-1:0]       a,
        input logic [SHAMT_W-1:0] s
    );
        return a >> s;
    endfunction

    function automatic logic [N-1:0] shift_right_arithmetic(
        input logic [N-1:0]       a,
        input logic [SHAMT_W-1:0] s
    );
        return $unsigned($signed(a) >>> s);
    endfunction

endpackage

// File: rtl/shift_unit.sv
// Combinational 32-bit shifter: SLL, SRL, SRA, or pass-through.
// Reserved op passes the operand through untouched.
module shift_unit
    import shift_pkg::*;
(
    input  logic [N-1:0]       in,
    input  logic [SHAMT_W-1:0] shamt,
    input  shift_op_t          op,
    output logic [N-1:0]       out
);

    // Select the shifted value for the requested op
    always_comb begin
        out = in;
        unique case (op)
            SHIFT_SLL:  out = shift_left_logical(in, shamt);
            SHIFT_SRL:  out = shift_right_logical(in, shamt);
            SHIFT_SRA:  out = shift_right_arithmetic(in, shamt);
            SHIFT_PASS: out = in;
            default:    out = in;
        endcase
    end

endmodule

// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end for one shared shift unit.
// Result is registered and held, tagged with its requester id.
module shifter_arbiter
    import shift_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [1:0][1:0]         req_op,
    input  logic [1:0][N-1:0]       req_in,
    input  logic [1:0][SHAMT_W-1:0] req_shamt,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [N-1:0]            resp_out,
    output logic                    resp_id
);

    typedef logic [0:0] arb_state_t;
    localparam arb_state_t S_IDLE = 1'b0;
    localparam arb_state_t S_FULL = 1'b1;

    arb_state_t state;
    logic       last_grant;
    logic [1:0] grant;
    logic       can_accept;
    logic       sel;
    logic       req_hs;
    logic       resp_hs;
    shift_req_t cur;
    logic [N-1:0] shift_res;

    // Round-robin grant: contention goes to the requester that did not win last
    always_comb begin
        grant = 2'b00;
        unique case (1'b1)
            (req_valid == 2'b11): grant = last_grant ? 2'b01 : 2'b10;
            (req_valid == 2'b01): grant = 2'b01;
            (req_valid == 2'b10): grant = 2'b10;
            default:              grant = 2'b00;
        endcase
    end

    assign can_accept = (state == S_IDLE) || resp_ready;
    assign req_ready  = (rst && can_accept) ? grant : 2'b00;
    assign req_hs     = |(req_valid & req_ready);
    assign resp_valid = (state == S_FULL);
    assign resp_hs    = resp_valid && resp_ready;
    assign sel        = grant[1];

    // Steer the granted requester's operands into the shared shifter
    always_comb begin
        cur.op    = shift_op_t'(req_op[sel]);
        cur.in    = req_in[sel];
        cur.shamt = req_shamt[sel];
    end

    shift_unit u_shift (
        .in    (cur.in),
        .shamt (cur.shamt),
        .op    (cur.op),
        .out   (shift_res)
    );

    // Output register and FSM: load on request, drain on response
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            resp_out   <= '0;
            resp_id    <= 1'b0;
            last_grant <= 1'b1;
        end else if (req_hs) begin
            state      <= S_FULL;
            resp_out   <= shift_res;
            resp_id    <= sel;
            last_grant <= sel;
        end else if (resp_hs) begin
            state      <= S_IDLE;
        end
    end

endmodule

// File: tb/tb_shifter_arbiter.sv
// Scoreboard bench for shifter_arbiter with a behavioural reference.
// Directed scenarios followed by constrained-random traffic.
module tb_shifter_arbiter;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0][1:0]  req_op = '0;
    logic [1:0][31:0] req_in = '0;
    logic [1:0][4:0]  req_shamt = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_out;
    logic             resp_id;

    shifter_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_in     (req_in),
        .req_shamt  (req_shamt),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_out   (resp_out),
        .resp_id    (resp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] out;
        logic        id;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    logic             m_full = 1'b0;
    logic             m_last = 1'b1;
    logic [1:0]       last_ready = 2'b00;
    logic [1:0][1:0]  nx_op = '0;
    logic [1:0][31:0] nx_in = '0;
    logic [1:0][4:0]  nx_shamt = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference shift from the arithmetic meaning of each op
    function automatic logic [31:0] ref_shift(input int op,
                                              input logic [31:0] a,
                                              input int s);
        longint unsigned p = 1;
        longint unsigned x;
        logic [31:0] na;
        repeat (s) p = p * 2;
        case (op)
            0: begin
                x = a;
                x = x * p;
                return x[31:0];
            end
            1: begin
                x = a;
                x = x / p;
                return x[31:0];
            end
            2: begin
                if (a[31]) begin
                    na = ~a;
                    x = na;
                    x = x / p;
                    na = x[31:0];
                    return ~na;
                end
                x = a;
                x = x / p;
                return x[31:0];
            end
            default: return a;
        endcase
    endfunction

    task automatic set_req(input int i, input int op,
                           input logic [31:0] a, input int s);
        nx_op[i]    = 2'(op);
        nx_in[i]    = a;
        nx_shamt[i] = 5'(s);
    endtask

    // Predict arbitration from the round-robin rules and queue results
    task automatic model_check();
        logic [1:0] g;
        logic [1:0] er;
        logic       can;
        exp_t       e;
        g = 2'b00;
        if (req_valid == 2'b11) g = m_last ? 2'b01 : 2'b10;
        else if (req_valid == 2'b01) g = 2'b01;
        else if (req_valid == 2'b10) g = 2'b10;
        can = !m_full || resp_ready;
        er = can ? g : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("resp_valid", 32'(resp_valid), 32'(m_full));
        if (er != 2'b00) begin
            e.id  = er[1];
            e.out = ref_shift(int'(req_op[e.id]), req_in[e.id],
                              int'(req_shamt[e.id]));
            q.push_back(e);
            m_full = 1'b1;
            m_last = e.id;
        end else if (m_full && resp_ready) begin
            m_full = 1'b0;
        end
        last_ready = req_ready;
    endtask

    task automatic step(input logic [1:0] v, input logic rr);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        req_op     = nx_op;
        req_in     = nx_in;
        req_shamt  = nx_shamt;
        req_valid  = v;
        resp_ready = rr;
        @(negedge clk);
        model_check();
    endtask

    task automatic rst_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst        = 1'b0;
            req_valid  = 2'b00;
            resp_ready = 1'b0;
            @(negedge clk);
            chk("ready_in_reset", 32'(req_ready), 32'h0);
            m_full     = 1'b0;
            m_last     = 1'b1;
            last_ready = 2'b00;
            q.delete();
        end
    endtask

    logic        hold_prev = 1'b0;
    logic [31:0] prev_out;
    logic        prev_id;

    // Monitor: pop on every response handshake, check stability when stalled
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (hold_prev) begin
                chk("hold_valid", 32'(resp_valid), 32'h1);
                chk("hold_out", resp_out, prev_out);
                chk("hold_id", 32'(resp_id), 32'(prev_id));
            end
            if (resp_valid && resp_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL resp_unexpected: got %h want none",
                             resp_out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("resp_out", resp_out, e.out);
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                end
            end
            hold_prev = resp_valid && !resp_ready;
            prev_out  = resp_out;
            prev_id   = resp_id;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        #500us;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] nv;
        logic       want_id;

        // Reset then idle
        rst_cycles(2);
        step(2'b00, 1'b0);
        chk("rst_out", resp_out, 32'h0);
        chk("rst_id", 32'(resp_id), 32'h0);
        chk("rst_valid", 32'(resp_valid), 32'h0);

        // Single SRA from requester 0
        set_req(0, 2, 32'h8000_00F0, 4);
        step(2'b01, 1'b1);
        step(2'b00, 1'b1);
        chk("sra_out", resp_out, 32'hF800_000F);
        chk("sra_id", 32'(resp_id), 32'h0);
        step(2'b00, 1'b1);
        chk("sra_one_cycle", 32'(resp_valid), 32'h0);

        // Contention from a fresh reset starts with requester 0
        rst_cycles(1);
        set_req(0, 0, 32'h0000_0001, 31);
        set_req(1, 1, 32'h8000_0000, 31);
        step(2'b11, 1'b1);
        step(2'b11, 1'b1);
        chk("cont0_out", resp_out, 32'h8000_0000);
        chk("cont0_id", 32'(resp_id), 32'h0);
        step(2'b11, 1'b1);
        chk("cont1_out", resp_out, 32'h0000_0001);
        chk("cont1_id", 32'(resp_id), 32'h1);
        repeat (3) step(2'b11, 1'b1);

        // Backpressure for 5 cycles, then release
        repeat (5) begin
            step(2'b11, 1'b0);
            chk("bp_ready", 32'(req_ready), 32'h0);
        end
        want_id = !m_last;
        step(2'b11, 1'b1);
        step(2'b00, 1'b1);
        chk("bp_release_id", 32'(resp_id), 32'(want_id));

        // Edge ops: zero shift and reserved op pass the operand through
        for (int op = 0; op < 4; op++) begin
            set_req(op % 2, op, 32'hDEAD_BEEF, (op == 3) ? 7 : 0);
            step((op % 2) ? 2'b10 : 2'b01, 1'b1);
            step(2'b00, 1'b1);
            chk("edge_op", resp_out, 32'hDEAD_BEEF);
        end

        // Reset while a result is held
        set_req(1, 0, 32'h1234_5678, 3);
        step(2'b10, 1'b0);
        step(2'b00, 1'b0);
        chk("mid_full", 32'(resp_valid), 32'h1);
        rst_cycles(1);
        step(2'b00, 1'b0);
        chk("mid_valid", 32'(resp_valid), 32'h0);
        set_req(0, 1, 32'hF0F0_0000, 8);
        set_req(1, 2, 32'h8000_1111, 12);
        step(2'b11, 1'b1);
        chk("mid_first_grant", 32'(req_ready), 32'h1);
        step(2'b00, 1'b1);

        // Random traffic with the hold rule honoured
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && !last_ready[i]) begin
                    nv[i] = 1'b1;
                end else begin
                    nv[i] = ($urandom_range(0, 9) < 6);
                    set_req(i, int'($urandom_range(0, 3)), $urandom,
                            ($urandom_range(0, 7) == 0) ? 0 :
                            int'($urandom_range(0, 31)));
                end
            end
            step(nv, $urandom_range(0, 3) != 0);
        end

        // Drain and confirm nothing is left outstanding
        repeat (3) step(2'b00, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
